// File: rtl/mux8_arb_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_arbiter_rr_pick.sv
// Round-robin picker: first requesting index scanning upward from (ptr+1) mod 8.
module rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate down so the nearest one after ptr wins;
    // i = N_REQ wraps to ptr itself, giving the last owner lowest priority.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux8_arbiter.sv
// 8:1 shared mux with round-robin arbitration, bounded hold time and a
// one-cycle break-before-make gap between tenures.
module mux8_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] sel,
    output logic             y,
    output logic             valid
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       hold_cnt;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             release_owner;

    rr_pick u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Owner drop and timeout in the same cycle collapse into one exit.
    assign release_owner = !req[sel] || (hold_cnt == HOLD_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            y        <= 1'b0;
            valid    <= 1'b0;
            hold_cnt <= '0;
            ptr      <= 3'd7;
        end else begin
            // y/valid trail the grant by one cycle; y holds when no owner sampled.
            valid <= (state == GRANT);
            if (state == GRANT) begin
                y <= din[sel];
            end

            unique case (state)
                IDLE, GAP: begin
                    if (pick_found) begin
                        state    <= GRANT;
                        gnt      <= onehot(pick_idx);
                        sel      <= pick_idx;
                        hold_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_owner) begin
                        state <= GAP;
                        gnt   <= '0;
                        ptr   <= sel;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_arbiter.sv
// Scoreboard bench for mux8_arbiter: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares them and checks grant invariants.
module tb_mux8_arbiter;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] din = 8'h00;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
    logic       valid;

    mux8_arbiter #(
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .req      (req),
        .din      (din),
        .gnt      (gnt),
        .sel      (sel),
        .y        (y),
        .valid    (valid)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       y;
        logic       full;   // also check sel/y when idle (reset values)
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cycles = 0;
    int         run_len = 0;
    logic [7:0] last_gnt = 8'h00;
    logic       done = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycles, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        cycles++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt", gnt, e.gnt);
            check("valid", {7'b0, valid}, {7'b0, e.valid});
            if (e.gnt != 8'h00 || e.full) check("sel", {5'b0, sel}, {5'b0, e.sel});
            if (e.valid || e.full) check("y", {7'b0, y}, {7'b0, e.y});
        end
        if (!$isunknown(gnt)) begin
            check("gnt_onehot0", {7'b0, $onehot0(gnt)}, 8'h01);
            if (gnt != 8'h00) begin
                check("sel_vs_gnt", gnt, 8'b1 << sel);
                run_len = (gnt == last_gnt) ? run_len + 1 : 1;
                check("tenure_len", {7'b0, run_len <= MAX_HOLD}, 8'h01);
            end else begin
                run_len = 0;
            end
            last_gnt = gnt;
        end
        if (done) begin
            check("queue_drained", 8'(exp_q.size()), 8'h00);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else if (cycles > 5000) begin
            errors++;
            $display("FAIL watchdog: got %0d cycles, expected at most 5000", cycles);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    // Sets this cycle's inputs and queues the outputs expected during this cycle.
    task automatic cyc(input logic r, input logic [7:0] rq, input logic [7:0] d,
                       input logic [7:0] eg, input logic [2:0] es, input logic ev,
                       input logic ey, input logic full);
        @(posedge clk);
        #1;
        reset = r;
        req   = rq;
        din   = d;
        exp_q.push_back('{gnt: eg, sel: es, valid: ev, y: ey, full: full});
    endtask

    task automatic drive(input logic r, input logic [7:0] rq, input logic [7:0] d);
        @(posedge clk);
        #1;
        reset = r;
        req   = rq;
        din   = d;
    endtask

    task automatic start(input logic [7:0] rq, input logic [7:0] d);
        drive(1'b1, 8'h00, 8'h00);
        cyc(1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, rq, d, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // One tenure of len grant cycles; last_rq applies in the final grant cycle.
    task automatic tenure(input logic [2:0] owner, input int len, input logic [7:0] rq,
                          input logic [7:0] last_rq, input logic [7:0] d);
        for (int i = 0; i < len; i++) begin
            cyc(1'b0, (i == len - 1) ? last_rq : rq, d, 8'b1 << owner, owner,
                i != 0, (i != 0) ? d[owner] : 1'b0, 1'b0);
        end
    endtask

    task automatic gap(input logic [2:0] owner, input logic [7:0] rq, input logic [7:0] d);
        cyc(1'b0, rq, d, 8'h00, 3'd0, 1'b1, d[owner], 1'b0);
    endtask

    task automatic idle(input logic [7:0] rq, input logic [7:0] d);
        cyc(1'b0, rq, d, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Single requester: timeout, one gap, re-grant.
        start(8'h01, 8'h01);
        tenure(3'd0, MAX_HOLD, 8'h01, 8'h01, 8'h01);
        gap(3'd0, 8'h01, 8'h01);
        tenure(3'd0, 3, 8'h01, 8'h01, 8'h01);

        // All requesting: full rotation with din=A5, wrapping back to 0.
        start(8'hFF, 8'hA5);
        for (int k = 0; k < 8; k++) begin
            tenure(3'(k), MAX_HOLD, 8'hFF, 8'hFF, 8'hA5);
            gap(3'(k), 8'hFF, 8'hA5);
        end
        tenure(3'd0, MAX_HOLD, 8'hFF, 8'hFF, 8'hA5);
        gap(3'd0, 8'hFF, 8'hA5);

        // Owner 3 drops early; 3 re-requests in the gap but 7 must win (ptr=3).
        start(8'h88, 8'h08);
        tenure(3'd3, 6, 8'h88, 8'h80, 8'h08);
        gap(3'd3, 8'h88, 8'h08);
        tenure(3'd7, 3, 8'h88, 8'h08, 8'h08);
        gap(3'd7, 8'h08, 8'h08);
        tenure(3'd3, 2, 8'h08, 8'h08, 8'h08);

        // Drop coinciding with timeout: one gap, then idle, then pick after ptr=1.
        start(8'h02, 8'h02);
        tenure(3'd1, MAX_HOLD, 8'h02, 8'h00, 8'h02);
        gap(3'd1, 8'h00, 8'h02);
        idle(8'h03, 8'h02);
        tenure(3'd0, 2, 8'h03, 8'h03, 8'h02);

        // Reset during requester 5's grant: outputs clear, re-grant with no gap.
        start(8'h20, 8'h20);
        tenure(3'd5, 4, 8'h20, 8'h20, 8'h20);
        cyc(1'b1, 8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 8'h20, 8'h20, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
        tenure(3'd5, 3, 8'h20, 8'h20, 8'h20);

        @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
